// File: rtl/seq_gen_pkg.sv
// Shared encodings for the serial frame generator: FSM state codes and the frame preamble.
package seq_gen_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE_A = 3'd1,
    PRE_B = 3'd2,
    PRE_C = 3'd3,
    DATA  = 3'd4,
    GAP   = 3'd5
  } gen_state_t;

  // Bit 2 goes out first; the receiver's detector keys on this pattern.
  localparam logic [2:0] PREAMBLE = 3'b101;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out register: captures a word on load, shifts left (zero fill) on shift.
// Latency: msb reflects the loaded word the cycle after load; no backpressure, caller sequences load/shift.
module piso_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              msb
);

  logic [DATA_W-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= sr << 1;
    end
  end

  assign msb = sr[DATA_W-1];

endmodule

// File: rtl/sequence_generator_moore.sv
// Frames a payload word as "101" + DATA_W bits MSB first + GAP_BITS zeros; first bit the cycle after handshake.
// tx_ready is high only in IDLE, so a waiting source is held off for the whole frame plus gap.
module sequence_generator_moore
  import seq_gen_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int GAP_BITS = 2,
  parameter int CNT_W    = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              out_sequence,
  output logic              out_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam int GAP_W = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;

  gen_state_t       state;
  gen_state_t       state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_cnt_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_cnt_nxt;
  logic             load;
  logic             shift;
  logic             msb;

  piso_shift_reg #(
    .DATA_W(DATA_W)
  ) u_piso (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .shift(shift),
    .din  (tx_data),
    .msb  (msb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  // Outputs depend only on the state register and the shift register msb.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    gap_cnt_nxt  = gap_cnt;
    load         = 1'b0;
    shift        = 1'b0;
    tx_ready     = 1'b0;
    out_sequence = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    frame_done   = 1'b0;

    case (state)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          load      = 1'b1;
          state_nxt = PRE_A;
        end
      end
      PRE_A: begin
        out_sequence = PREAMBLE[2];
        out_valid    = 1'b1;
        busy         = 1'b1;
        state_nxt    = PRE_B;
      end
      PRE_B: begin
        out_sequence = PREAMBLE[1];
        out_valid    = 1'b1;
        busy         = 1'b1;
        state_nxt    = PRE_C;
      end
      PRE_C: begin
        out_sequence = PREAMBLE[0];
        out_valid    = 1'b1;
        busy         = 1'b1;
        bit_cnt_nxt  = CNT_W'(DATA_W);
        state_nxt    = DATA;
      end
      DATA: begin
        out_sequence = msb;
        out_valid    = 1'b1;
        busy         = 1'b1;
        shift        = 1'b1;
        bit_cnt_nxt  = bit_cnt - CNT_W'(1);
        if (bit_cnt == CNT_W'(1)) begin
          frame_done = 1'b1;
          if (GAP_BITS == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt   = GAP;
            gap_cnt_nxt = GAP_W'(GAP_BITS);
          end
        end
      end
      GAP: begin
        busy        = 1'b1;
        gap_cnt_nxt = gap_cnt - GAP_W'(1);
        if (gap_cnt <= GAP_W'(1)) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sequence_generator_moore.sv
// Bench for the serial frame generator: constant vector table, hand-written corner sequences, random traffic vs. a frame-queue model.
module tb_sequence_generator_moore;

  localparam int DATA_W   = 8;
  localparam int GAP_BITS = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              tx_valid = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_ready;
  logic              out_sequence;
  logic              out_valid;
  logic              busy;
  logic              frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sequence_generator_moore #(
    .DATA_W  (DATA_W),
    .GAP_BITS(GAP_BITS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .out_sequence(out_sequence),
    .out_valid   (out_valid),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  // Observed outputs, order: out_sequence, out_valid, busy, frame_done, tx_ready.
  typedef struct packed {
    logic s;
    logic v;
    logic b;
    logic d;
    logic r;
  } obs_t;

  typedef struct {
    logic              rst;
    logic              vld;
    logic [DATA_W-1:0] data;
    obs_t              want;
  } vec_t;

  vec_t tbl[$];
  obs_t exp_q[$];
  obs_t cur;

  function automatic obs_t mk(logic s, logic v, logic b, logic d, logic r);
    obs_t o;
    o.s = s; o.v = v; o.b = b; o.d = d; o.r = r;
    return o;
  endfunction

  function automatic obs_t idle_obs();
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic check(string name, obs_t want);
    obs_t got;
    got = {out_sequence, out_valid, busy, frame_done, tx_ready};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got seq/vld/busy/done/rdy=%b required %b", name, $time, got, want);
    end
  endtask

  task automatic check_int(string name, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  // Model: a frame is a list of per-cycle output records queued on handshake.
  task automatic model_edge(logic rstv, logic vld, logic [DATA_W-1:0] d);
    if (!rstv) begin
      exp_q.delete();
      cur = idle_obs();
      return;
    end
    if (cur.r && vld) begin
      exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
      for (int i = DATA_W - 1; i >= 0; i--)
        exp_q.push_back(mk(d[i], 1'b1, 1'b1, (i == 0), 1'b0));
      repeat (GAP_BITS) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    end
    cur = (exp_q.size() > 0) ? exp_q.pop_front() : idle_obs();
  endtask

  task automatic step(string name, logic rstv, logic vld, logic [DATA_W-1:0] d);
    rst_n    = rstv;
    tx_valid = vld;
    tx_data  = d;
    @(posedge clk);
    model_edge(rstv, vld, d);
    #1;
    check(name, cur);
  endtask

  task automatic add_vec(logic rst, logic vld, logic [DATA_W-1:0] data,
                         logic s, logic v, logic b, logic d, logic r);
    vec_t e;
    e.rst = rst; e.vld = vld; e.data = data; e.want = mk(s, v, b, d, r);
    tbl.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs[$];
    logic bits[$];
    int last_one;
    int hits;
    int hit_at;
    logic [2:0] pre;

    cur = idle_obs();

    // Reset held 3 cycles with tx_valid high, then release.
    add_vec(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add_vec(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add_vec(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Single frame of 8'hA5: 101 10100101 00 then idle.
    add_vec(1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    #1;
    check("reset_t0", idle_obs());
    foreach (tbl[i]) begin
      rst_n    = tbl[i].rst;
      tx_valid = tbl[i].vld;
      tx_data  = tbl[i].data;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), tbl[i].want);
    end

    // Back-to-back: tx_valid held, 8'hFF then 8'h00.
    for (int c = 0; c < 32; c++) begin
      logic              v;
      logic [DATA_W-1:0] d;
      v = (hs.size() < 2);
      d = (hs.size() == 0) ? 8'hFF : 8'h00;
      if (v && tx_ready) hs.push_back(c);
      step("b2b", 1'b1, v, d);
      bits.push_back(out_sequence);
    end
    check_int("b2b_hs_count", hs.size(), 2);
    if (hs.size() == 2) begin
      check_int("b2b_spacing", hs[1] - hs[0], DATA_W + 3 + GAP_BITS + 1);
      last_one = -1;
      for (int j = 0; j < hs[1]; j++) if (bits[j]) last_one = j;
      check_int("b2b_zero_run", hs[1] - last_one - 1, GAP_BITS + 1);
    end

    // Loopback through a "101" detector (overlapping) with an all-zero payload.
    bits.delete();
    step("loop", 1'b1, 1'b1, 8'h00);
    bits.push_back(out_sequence);
    for (int c = 0; c < 15; c++) begin
      step("loop", 1'b1, 1'b0, 8'h00);
      bits.push_back(out_sequence);
    end
    hits = 0;
    hit_at = -1;
    for (int i = 2; i < bits.size(); i++) begin
      if (bits[i-2] && !bits[i-1] && bits[i]) begin
        hits++;
        hit_at = i;
      end
    end
    check_int("loop_hits", hits, 1);
    check_int("loop_align", hit_at, 2);

    // Mid-frame reset during DATA bit 4, then a clean restart.
    step("mid", 1'b1, 1'b1, 8'hFF);
    for (int c = 0; c < 7; c++) step("mid", 1'b1, 1'b0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", idle_obs());
    model_edge(1'b0, 1'b0, '0);
    step("rst_hold", 1'b0, 1'b1, 8'hFF);
    step("rst_hold", 1'b0, 1'b1, 8'hFF);
    step("rst_rel", 1'b1, 1'b0, 8'h00);
    step("rst_rel", 1'b1, 1'b0, 8'h00);
    step("restart", 1'b1, 1'b1, 8'h3C);
    pre[2] = out_sequence;
    step("restart", 1'b1, 1'b0, 8'h00);
    pre[1] = out_sequence;
    step("restart", 1'b1, 1'b0, 8'h00);
    pre[0] = out_sequence;
    check_int("restart_preamble", int'(pre), 5);
    for (int c = 0; c < 12; c++) step("restart", 1'b1, 1'b0, 8'h00);

    // Hold-off: tx_valid pulsed with other data while the frame is in flight.
    step("hold", 1'b1, 1'b1, 8'hC3);
    for (int c = 0; c < 13; c++)
      step("hold", 1'b1, ($urandom_range(0, 1) == 1), DATA_W'($urandom));
    step("hold_end", 1'b1, 1'b0, 8'h00);

    // Random traffic with occasional resets.
    for (int c = 0; c < 800; c++)
      step("rand", ($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), DATA_W'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
